if_fetch_stage: RTL and testbench

- Producer side of the IF->ID pipeline register.
- Holds the 64-bit PC and issues in-order requests to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Buffers returned words in a small FIFO and presents {pc, instruction, valid} to the IF/ID buffer.
- Honours stall from hazard logic and redirect (branch/jump/exception) from later stages, discarding in-flight wrong-path responses.

---
 rtl/if_fetch_stage.sv | 137 +++++++++++++
 tb/tb_if_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order requests to instruction memory,
// buffers returned words in a small FIFO and hands {pc, instruction, valid} to IF/ID.
//
// Handshakes: the request channel transfers on a cycle where imem_req_valid and
// imem_req_ready are both high. imem_req_valid and imem_req_addr do not depend on
// imem_req_ready, and they stay stable until the transfer unless a redirect or reset
// intervenes. The response channel is valid-only: a word is consumed on every cycle
// imem_rsp_valid is high. The IF/ID side pops the head on valid_out & !stall.
module if_fetch_stage #(
  parameter int             N        = 32,
  parameter int             DEPTH    = 2,
  parameter logic [2*N-1:0] RESET_PC = '0,
  parameter logic [N-1:0]   NOP      = 32'h00000013
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           redirect_valid,
  input  logic [2*N-1:0] redirect_pc,
  output logic           imem_req_valid,
  input  logic           imem_req_ready,
  output logic [2*N-1:0] imem_req_addr,
  input  logic           imem_rsp_valid,
  input  logic [N-1:0]   imem_rsp_data,
  output logic [2*N-1:0] pc_out,
  output logic [N-1:0]   instruction_out,
  output logic           valid_out,
  output logic           o_dbg_state
);

  localparam int AW = 2 * N;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [AW-1:0] r_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic [0:0]    r_state;
  logic [PW-1:0] r_fifo_rd;
  logic [PW-1:0] r_fifo_wr;
  logic [PW-1:0] r_sq_rd;
  logic [PW-1:0] r_sq_wr;

  logic [AW-1:0] r_fifo_pc  [DEPTH];
  logic [N-1:0]  r_fifo_ins [DEPTH];
  logic [AW-1:0] r_sq_pc    [DEPTH];

  logic          w_credit;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_push;
  logic          w_drop_rsp;
  logic          w_valid;
  logic          w_pop;
  logic [CW-1:0] w_outst_rsp;

  // Buffered words plus words still in flight may never exceed the FIFO depth,
  // so every response that is not discarded is guaranteed a free slot.
  assign w_credit    = ({1'b0, r_count} + {1'b0, r_outst}) < DEPTH_W;
  assign w_req_valid = !rst && !redirect_valid && w_credit;
  assign w_accept    = w_req_valid && imem_req_ready;
  assign w_push      = imem_rsp_valid && (r_state == ST_RUN) && !redirect_valid && !rst;
  assign w_drop_rsp  = imem_rsp_valid && (r_state == ST_DRAIN);
  assign w_valid     = !rst && !redirect_valid && (r_count != '0);
  assign w_pop       = w_valid && !stall;
  assign w_outst_rsp = r_outst - CW'(imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_count   <= '0;
      r_outst   <= '0;
      r_drop    <= '0;
      r_state   <= ST_RUN;
      r_fifo_rd <= '0;
      r_fifo_wr <= '0;
      r_sq_rd   <= '0;
      r_sq_wr   <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path. r_drop is always a
      // subset of r_outst, so the new discard count is simply what remains in flight.
      r_pc      <= redirect_pc;
      r_count   <= '0;
      r_fifo_rd <= '0;
      r_fifo_wr <= '0;
      r_sq_rd   <= '0;
      r_sq_wr   <= '0;
      r_outst   <= w_outst_rsp;
      r_drop    <= w_outst_rsp;
      r_state   <= (w_outst_rsp != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (w_accept) begin
        r_pc    <= r_pc + AW'(4);
        r_sq_wr <= r_sq_wr + PW'(1);
      end
      if (w_push) begin
        r_fifo_wr <= r_fifo_wr + PW'(1);
        r_sq_rd   <= r_sq_rd + PW'(1);
      end
      if (w_pop) begin
        r_fifo_rd <= r_fifo_rd + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_outst <= r_outst + CW'(w_accept) - CW'(imem_rsp_valid);
      if (w_drop_rsp) begin
        r_drop <= r_drop - CW'(1);
        if (r_drop == CW'(1)) begin
          r_state <= ST_RUN;
        end
      end
    end
  end

  // Storage arrays carry no reset; their contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sq_pc[r_sq_wr] <= r_pc;
    end
    if (w_push) begin
      r_fifo_pc[r_fifo_wr]  <= r_sq_pc[r_sq_rd];
      r_fifo_ins[r_fifo_wr] <= imem_rsp_data;
    end
  end

  assign imem_req_valid  = w_req_valid;
  assign imem_req_addr   = r_pc;
  assign valid_out       = w_valid;
  assign pc_out          = w_valid ? r_fifo_pc[r_fifo_rd] : '0;
  assign instruction_out = w_valid ? r_fifo_ins[r_fifo_rd] : NOP;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a latency-configurable memory, an epoch-tagged fetch model
// feeding an expected queue, and a monitor that checks every word IF/ID consumes.
module tb_if_fetch_stage;
  localparam int N     = 32;
  localparam int DEPTH = 2;
  localparam int AW    = 2 * N;
  localparam logic [AW-1:0] RESET_PC = '0;
  localparam logic [N-1:0]  NOP      = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [N-1:0]  imem_rsp_data;
  logic [AW-1:0] pc_out;
  logic [N-1:0]  instruction_out;
  logic          valid_out;
  logic          o_dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  if_fetch_stage #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- model state ----------------
  typedef struct {
    int            due;
    logic [AW-1:0] exp_pc;
    logic [N-1:0]  exp_data;
    logic [N-1:0]  rdata;
    int            epoch;
  } mem_t;

  mem_t              inflight[$];
  logic [AW+N-1:0]   exp_q[$];
  int                checks   = 0;
  int                errors   = 0;
  int                cyc      = 0;
  int                epoch    = 0;
  int                last_due = 0;
  int                lat      = 1;
  logic [AW-1:0]     model_pc = RESET_PC;

  function automatic logic [N-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a * 64'h0000_0001_0001_0003 + 64'h0000_0000_1357_9bdf;
    return t[N-1:0] ^ t[AW-1:N];
  endfunction

  function automatic bit stale_pending();
    foreach (inflight[i]) if (inflight[i].epoch != epoch) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit rsp_next();
    return inflight.size() != 0 && inflight[0].due <= cyc;
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic r, input logic st, input logic rv,
                      input logic [AW-1:0] rpc, input logic rdy);
    mem_t m;
    int   due;
    bit   exp_req;
    @(negedge clk);
    rst            = r;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = !r && rsp_next();
    imem_rsp_data  = imem_rsp_valid ? inflight[0].rdata : N'($urandom());
    #1;
    exp_req = !r && !rv && (exp_q.size() + inflight.size() < DEPTH);
    check("req_valid", imem_req_valid, exp_req);
    if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
    check("drain_state", o_dbg_state, stale_pending());
    if (!r) begin
      check("valid_out", valid_out, !rv && exp_q.size() != 0);
      if (!valid_out) begin
        check("idle_pc", pc_out, '0);
        check("idle_instr", instruction_out, NOP);
      end
    end
    // model effects of the coming clock edge
    if (imem_rsp_valid) begin
      m = inflight.pop_front();
      if (m.epoch == epoch && !rv) exp_q.push_back({m.exp_pc, m.exp_data});
    end
    if (!r && imem_req_valid && rdy) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      inflight.push_back('{due: due, exp_pc: model_pc, exp_data: mem_word(model_pc),
                           rdata: mem_word(imem_req_addr), epoch: epoch});
      model_pc = model_pc + 64'd4;
    end
    if (rv) begin
      epoch++;
      exp_q.delete();
      model_pc = rpc;
    end
    if (r) begin
      epoch++;
      inflight.delete();
      exp_q.delete();
      model_pc = RESET_PC;
      last_due = cyc;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic wait_inflight(input int n);
    int k;
    k = 0;
    while (inflight.size() < n && k < 30) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      k++;
    end
    check("wait_inflight_timeout", (inflight.size() >= n), 1'b1);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [AW+N-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && redirect_valid === 1'b0 && valid_out && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %h instr %h expected nothing (cycle %0d)",
                   pc_out, instruction_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", pc_out, e[AW+N-1:N]);
          check("pop_instr", AW'(instruction_out), AW'(e[N-1:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [AW-1:0] rpc;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    lat = 1;
    run(10);

    // stall: fetch stops once credits run out, head is held
    repeat (5) step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    run(6);

    // redirect with two requests in flight at latency 3
    lat = 3;
    wait_inflight(2);
    step(1'b0, 1'b0, 1'b1, 64'h1000, 1'b1);
    run(12);

    // redirect on the same cycle a stale response returns
    wait_inflight(2);
    k = 0;
    while (!rsp_next() && k < 10) begin run(1); k++; end
    check("rsp_wait_timeout", rsp_next(), 1'b1);
    step(1'b0, 1'b0, 1'b1, 64'h2000, 1'b1);
    run(12);

    // back-to-back redirects, second one wins
    wait_inflight(2);
    step(1'b0, 1'b0, 1'b1, 64'h3000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 64'h4000, 1'b1);
    run(12);

    // PC wraps modulo 2^64
    lat = 1;
    step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    run(8);

    // ready toggling: address held while not accepted
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
    run(4);

    // reset in the middle of a drain
    lat = 4;
    wait_inflight(2);
    step(1'b0, 1'b0, 1'b1, 64'h5000, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    run(10);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      rpc = {$urandom(), $urandom()};
      rpc[1:0] = 2'b00;
      if ($urandom_range(0, 19) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) < 7);
    end

    // let everything in flight come back and be consumed
    k = 0;
    while ((inflight.size() != 0 || exp_q.size() != 0) && k < 200) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      k++;
    end
    check("final_drain", exp_q.size() + inflight.size(), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
